sc_fifo: RTL and testbench

Single-clock first-in/first-out buffer, the queue-ordered counterpart to our single-clock stack, sharing its port style and flag semantics so either can sit behind the same producer/consumer logic. It stores `2**fifo_depth` words in an inferred RAM with independent wrap-around read and write pointers. It provides registered full/empty/almost flags, an occupancy count, sticky overflow/underflow error flags and a synchronous clear.

---
 rtl/sc_fifo.sv | 183 ++++++++++++++++++
 tb/tb_sc_fifo.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/sc_fifo.sv
// -----------------------------------------------------------------------------
// sc_fifo
//
// Single-clock first-in/first-out buffer holding 2**fifo_depth words of
// data_width bits in an inferred RAM. Independent read and write pointers wrap
// naturally at fifo_depth bits. Status flags, occupancy and the sticky error
// flags are all registered and derived from the next occupancy value, so every
// status output describes the same cycle as use_words.
//
// Ports
//   clk           in   rising-edge clock for all state
//   reset_n       in   asynchronous active-low reset
//   wr            in   write request
//   data_in       in   write data (data_width)
//   rd            in   read request
//   data_out      out  registered read data (data_width), held between reads
//   full          out  occupancy == 2**fifo_depth
//   empty         out  occupancy == 0
//   almost_full   out  occupancy >= almost_full_lvl
//   almost_empty  out  occupancy <= almost_empty_lvl
//   use_words     out  occupancy, 0 .. 2**fifo_depth (fifo_depth+1 bits)
//   overflow      out  sticky: write requested while full
//   underflow     out  sticky: read requested while empty
//   clear         in   synchronous flush, active-high, overrides rd/wr
// -----------------------------------------------------------------------------
module sc_fifo #(
    parameter int data_width       = 32,
    parameter int fifo_depth       = 10,
    parameter int almost_full_lvl  = 2**fifo_depth - 2,
    parameter int almost_empty_lvl = 2
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  wr,
    input  logic [data_width-1:0] data_in,
    input  logic                  rd,
    output logic [data_width-1:0] data_out,
    output logic                  full,
    output logic                  empty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic [fifo_depth:0]   use_words,
    output logic                  overflow,
    output logic                  underflow,
    input  logic                  clear
);

    localparam int capacity = 2**fifo_depth;

    localparam logic [fifo_depth:0]   capacity_c = (fifo_depth+1)'(capacity);
    localparam logic [fifo_depth:0]   af_lvl_c   = (fifo_depth+1)'(almost_full_lvl);
    localparam logic [fifo_depth:0]   ae_lvl_c   = (fifo_depth+1)'(almost_empty_lvl);
    localparam logic [fifo_depth:0]   cnt_one_c  = (fifo_depth+1)'(1);
    localparam logic [fifo_depth-1:0] ptr_one_c  = fifo_depth'(1);

    // Handshake: there is no ready/valid pair on this block. A request is taken
    // in the cycle it is presented if the matching registered flag allows it:
    // a write is accepted when wr & ~full, a read when rd & ~empty. A refused
    // request is not retried by the FIFO; it is dropped and recorded in the
    // sticky overflow/underflow flag instead. clear overrides both requests.

    // Storage. Not reset: contents are undefined until written.
    logic [data_width-1:0] ram [0:capacity-1];

    logic [fifo_depth-1:0] wr_ptr_q, wr_ptr_d;
    logic [fifo_depth-1:0] rd_ptr_q, rd_ptr_d;
    logic [fifo_depth:0]   count_q, count_d;
    logic [data_width-1:0] data_out_q, data_out_d;
    logic                  full_q, full_d;
    logic                  empty_q, empty_d;
    logic                  almost_full_q, almost_full_d;
    logic                  almost_empty_q, almost_empty_d;
    logic                  overflow_q, overflow_d;
    logic                  underflow_q, underflow_d;

    logic                  wr_accept;
    logic                  rd_accept;
    logic                  ram_we;

    // Acceptance uses only the registered flags, so a simultaneous read does
    // not open a slot for a write in the same cycle when full (and vice versa
    // when empty).
    assign wr_accept = wr & ~full_q;
    assign rd_accept = rd & ~empty_q;

    // A clear cycle must leave the RAM untouched, including the word that a
    // concurrent wr would otherwise have stored.
    assign ram_we = wr_accept & ~clear;

    always_comb begin
        wr_ptr_d       = wr_ptr_q;
        rd_ptr_d       = rd_ptr_q;
        count_d        = count_q;
        data_out_d     = data_out_q;
        overflow_d     = overflow_q;
        underflow_d    = underflow_q;
        full_d         = 1'b0;
        empty_d        = 1'b1;
        almost_full_d  = 1'b0;
        almost_empty_d = 1'b1;

        if (clear) begin
            // Flush: pointers and count to zero, errors cleared, data_out kept.
            wr_ptr_d    = '0;
            rd_ptr_d    = '0;
            count_d     = '0;
            overflow_d  = 1'b0;
            underflow_d = 1'b0;
        end else begin
            if (wr_accept) begin
                wr_ptr_d = wr_ptr_q + ptr_one_c;
            end
            if (rd_accept) begin
                rd_ptr_d   = rd_ptr_q + ptr_one_c;
                data_out_d = ram[rd_ptr_q];
            end

            unique case ({wr_accept, rd_accept})
                2'b10:   count_d = count_q + cnt_one_c;
                2'b01:   count_d = count_q - cnt_one_c;
                default: count_d = count_q;
            endcase

            // Errors look at the raw request against the registered flag.
            if (wr & full_q) begin
                overflow_d = 1'b1;
            end
            if (rd & empty_q) begin
                underflow_d = 1'b1;
            end

            // Flags from the next occupancy so they line up with use_words.
            full_d         = (count_d == capacity_c);
            empty_d        = (count_d == '0);
            almost_full_d  = (count_d >= af_lvl_c);
            almost_empty_d = (count_d <= ae_lvl_c);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
            data_out_q     <= '0;
            full_q         <= 1'b0;
            empty_q        <= 1'b1;
            almost_full_q  <= 1'b0;
            almost_empty_q <= 1'b1;
            overflow_q     <= 1'b0;
            underflow_q    <= 1'b0;
        end else begin
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
            data_out_q     <= data_out_d;
            full_q         <= full_d;
            empty_q        <= empty_d;
            almost_full_q  <= almost_full_d;
            almost_empty_q <= almost_empty_d;
            overflow_q     <= overflow_d;
            underflow_q    <= underflow_d;
        end
    end

    // RAM write port. The read happens through data_out_d above, so a word
    // written at edge t can only be fetched by a read accepted at edge t+1.
    always_ff @(posedge clk) begin
        if (ram_we) begin
            ram[wr_ptr_q] <= data_in;
        end
    end

    assign data_out     = data_out_q;
    assign full         = full_q;
    assign empty        = empty_q;
    assign almost_full  = almost_full_q;
    assign almost_empty = almost_empty_q;
    assign use_words    = count_q;
    assign overflow     = overflow_q;
    assign underflow    = underflow_q;

endmodule

// File: tb/tb_sc_fifo.sv
// -----------------------------------------------------------------------------
// tb_sc_fifo
//
// Directed bench for sc_fifo. Instance a: fifo_depth=2 (4 words, default
// levels 2/2). Instance b: fifo_depth=3 (8 words, levels 6/2). A queue model
// per instance predicts occupancy, flags, sticky errors and read data.
// -----------------------------------------------------------------------------
module tb_sc_fifo;

  logic clk;
  logic reset_n;

  // instance a
  logic        wr_a, rd_a, clr_a;
  logic [31:0] din_a, dout_a;
  logic        full_a, empty_a, af_a, ae_a, ovf_a, unf_a;
  logic [2:0]  uw_a;

  // instance b
  logic        wr_b, rd_b, clr_b;
  logic [31:0] din_b, dout_b;
  logic        full_b, empty_b, af_b, ae_b, ovf_b, unf_b;
  logic [3:0]  uw_b;

  int checks;
  int failures;

  // model state, index 0 = a, 1 = b
  logic [31:0] exp_q[$];
  logic [31:0] exp_q_b[$];
  int          m_count[2];
  logic        m_ovf[2];
  logic        m_unf[2];
  logic [31:0] m_dout[2];

  sc_fifo #(.data_width(32), .fifo_depth(2)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .wr(wr_a), .data_in(din_a), .rd(rd_a),
    .data_out(dout_a), .full(full_a), .empty(empty_a), .almost_full(af_a),
    .almost_empty(ae_a), .use_words(uw_a), .overflow(ovf_a),
    .underflow(unf_a), .clear(clr_a)
  );

  sc_fifo #(.data_width(32), .fifo_depth(3), .almost_full_lvl(6),
            .almost_empty_lvl(2)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .wr(wr_b), .data_in(din_b), .rd(rd_b),
    .data_out(dout_b), .full(full_b), .empty(empty_b), .almost_full(af_b),
    .almost_empty(ae_b), .use_words(uw_b), .overflow(ovf_b),
    .underflow(unf_b), .clear(clr_b)
  );

  // clock / reset block
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic int cap_of(int id);
    return (id == 0) ? 4 : 8;
  endfunction

  function automatic int af_lvl_of(int id);
    return (id == 0) ? 2 : 6;
  endfunction

  task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic reset_model();
    for (int i = 0; i < 2; i++) begin
      m_count[i] = 0;
      m_ovf[i]   = 1'b0;
      m_unf[i]   = 1'b0;
      m_dout[i]  = 32'h0;
    end
    exp_q.delete();
    exp_q_b.delete();
  endtask

  // Scoreboard step: push on predicted accepted write, pop on accepted read.
  task automatic model_step(int id, logic w, logic [31:0] d, logic r, logic c);
    logic m_full, m_empty, aw, ar;
    if (c) begin
      m_count[id] = 0;
      m_ovf[id]   = 1'b0;
      m_unf[id]   = 1'b0;
      if (id == 0) exp_q.delete(); else exp_q_b.delete();
    end else begin
      m_full  = (m_count[id] == cap_of(id));
      m_empty = (m_count[id] == 0);
      aw = w & ~m_full;
      ar = r & ~m_empty;
      if (w & m_full)  m_ovf[id] = 1'b1;
      if (r & m_empty) m_unf[id] = 1'b1;
      if (ar) begin
        if (id == 0) m_dout[id] = exp_q.pop_front();
        else         m_dout[id] = exp_q_b.pop_front();
        m_count[id]--;
      end
      if (aw) begin
        if (id == 0) exp_q.push_back(d); else exp_q_b.push_back(d);
        m_count[id]++;
      end
    end
  endtask

  task automatic check_dut(int id, string ph);
    if (id == 0) begin
      check({ph, " a.use_words"},    32'(uw_a),    32'(m_count[0]));
      check({ph, " a.full"},         32'(full_a),  32'(m_count[0] == cap_of(0)));
      check({ph, " a.empty"},        32'(empty_a), 32'(m_count[0] == 0));
      check({ph, " a.almost_full"},  32'(af_a),    32'(m_count[0] >= af_lvl_of(0)));
      check({ph, " a.almost_empty"}, 32'(ae_a),    32'(m_count[0] <= 2));
      check({ph, " a.overflow"},     32'(ovf_a),   32'(m_ovf[0]));
      check({ph, " a.underflow"},    32'(unf_a),   32'(m_unf[0]));
      check({ph, " a.data_out"},     dout_a,       m_dout[0]);
    end else begin
      check({ph, " b.use_words"},    32'(uw_b),    32'(m_count[1]));
      check({ph, " b.full"},         32'(full_b),  32'(m_count[1] == cap_of(1)));
      check({ph, " b.empty"},        32'(empty_b), 32'(m_count[1] == 0));
      check({ph, " b.almost_full"},  32'(af_b),    32'(m_count[1] >= af_lvl_of(1)));
      check({ph, " b.almost_empty"}, 32'(ae_b),    32'(m_count[1] <= 2));
      check({ph, " b.overflow"},     32'(ovf_b),   32'(m_ovf[1]));
      check({ph, " b.underflow"},    32'(unf_b),   32'(m_unf[1]));
      check({ph, " b.data_out"},     dout_b,       m_dout[1]);
    end
  endtask

  // driver: one clock cycle on one instance, then compare against the model
  task automatic step(int id, string ph, logic w, logic [31:0] d, logic r, logic c);
    if (id == 0) begin
      wr_a = w; din_a = d; rd_a = r; clr_a = c;
    end else begin
      wr_b = w; din_b = d; rd_b = r; clr_b = c;
    end
    model_step(id, w, d, r, c);
    @(posedge clk);
    #1;
    wr_a = 1'b0; rd_a = 1'b0; clr_a = 1'b0;
    wr_b = 1'b0; rd_b = 1'b0; clr_b = 1'b0;
    check_dut(id, ph);
  endtask

  initial begin
    logic [31:0] pat [4];
    checks   = 0;
    failures = 0;
    reset_n  = 1'b0;
    wr_a = 1'b0; rd_a = 1'b0; clr_a = 1'b0; din_a = '0;
    wr_b = 1'b0; rd_b = 1'b0; clr_b = 1'b0; din_b = '0;
    reset_model();

    // reset state
    repeat (2) @(posedge clk);
    #1;
    check_dut(0, "reset");
    check_dut(1, "reset");
    reset_n = 1'b1;

    // reset asserted mid write burst, checked before any clock edge
    step(0, "burst", 1'b1, 32'hA0, 1'b0, 1'b0);
    step(0, "burst", 1'b1, 32'hA1, 1'b0, 1'b0);
    step(0, "burst", 1'b1, 32'hA2, 1'b1, 1'b0);
    wr_a = 1'b1; din_a = 32'hA3;
    #2;
    reset_n = 1'b0;
    #1;
    reset_model();
    check_dut(0, "async_reset");
    wr_a = 1'b0;
    @(posedge clk);
    #1;
    reset_n = 1'b1;
    check_dut(0, "after_reset");

    // ordering and pointer wrap, three passes
    pat[0] = 32'h11; pat[1] = 32'h22; pat[2] = 32'h33; pat[3] = 32'h44;
    for (int rep = 0; rep < 3; rep++) begin
      for (int i = 0; i < 4; i++) step(0, "order_wr", 1'b1, pat[i], 1'b0, 1'b0);
      for (int i = 0; i < 4; i++) step(0, "order_rd", 1'b0, 32'h0, 1'b1, 1'b0);
    end

    // full with simultaneous rd & wr: read wins, 0x55 dropped, overflow sets
    for (int i = 0; i < 4; i++) step(0, "fill", 1'b1, 32'h61 + 32'(i), 1'b0, 1'b0);
    step(0, "full_rdwr", 1'b1, 32'h55, 1'b1, 1'b0);
    for (int i = 0; i < 3; i++) step(0, "drain", 1'b0, 32'h0, 1'b1, 1'b0);
    step(0, "clear_a", 1'b0, 32'h0, 1'b0, 1'b1);

    // empty with simultaneous rd & wr: write wins, underflow sets
    step(0, "empty_rdwr", 1'b1, 32'hAA, 1'b1, 1'b0);
    step(0, "read_aa", 1'b0, 32'h0, 1'b1, 1'b0);
    step(0, "clear_a2", 1'b0, 32'h0, 1'b0, 1'b1);

    // steady streaming at occupancy 2
    step(0, "prime", 1'b1, 32'h0, 1'b0, 1'b0);
    step(0, "prime", 1'b1, 32'h1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++) step(0, "stream", 1'b1, 32'(i + 2), 1'b1, 1'b0);

    // thresholds and clear on the 8-deep instance
    step(1, "b_underflow", 1'b0, 32'h0, 1'b1, 1'b0);
    for (int i = 0; i < 6; i++) step(1, "b_fill", 1'b1, 32'hB0 + 32'(i), 1'b0, 1'b0);
    step(1, "b_read", 1'b0, 32'h0, 1'b1, 1'b0);
    step(1, "b_refill", 1'b1, 32'hB6, 1'b0, 1'b0);
    step(1, "b_clear_wr", 1'b1, 32'hEE, 1'b0, 1'b1);
    step(1, "b_post_wr", 1'b1, 32'h77, 1'b0, 1'b0);
    step(1, "b_post_rd", 1'b0, 32'h0, 1'b1, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
